ab_input_cond: RTL
==================

# ab_input_cond

Two-channel input conditioner that sits directly upstream of the A/B sequence FSM. It takes the raw asynchronous `btn_a`/`btn_b` inputs and synchronises and debounces each one. It then drives the clean, registered level inputs `A` and `B` that the FSM samples, plus one-cycle rise pulses. An optional pair-alignment stage makes near-simultaneous presses reach the FSM on the same clock edge.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised input must differ from the debounced state before that state flips; legal range ≥1.
- `PAIR_WINDOW`, default 3: hold window in cycles for pair alignment; legal range ≥1; ignored when alignment is compiled out.
- `clk  input  1  clock; all logic on rising edge`
- `rst  input  1  reset, synchronous, active-high`
- `btn_a  input  1  raw asynchronous input, channel A`
- `btn_b  input  1  raw asynchronous input, channel B`
- `A  output  1  conditioned level, channel A (to FSM input A)`
- `B  output  1  conditioned level, channel B (to FSM input B)`
- `a_rise  output  1  one-cycle pulse on the edge where A goes 0→1`
- `b_rise  output  1  one-cycle pulse on the edge where B goes 0→1`

## Operation
- Synchroniser per channel:
  - two flops, `s1` then `s2`; reset to 0.
- Debouncer per channel:
  - holds a debounced state `deb` and a counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`; both reset to 0.
  - Each edge where `s2 != deb`: `cnt` increments.
  - When the increment would reach `DEBOUNCE_CYCLES`: `deb` flips and `cnt` clears.
  - Each edge where `s2 == deb`: `cnt` clears. A bounce therefore restarts the count.
  - `cnt` never wraps.
- Output stage, alignment compiled out:
  - `A = deb_a` and `B = deb_b`, registered.
- Output stage, alignment compiled in: FSM with states IDLE, HOLD_A, HOLD_B, plus window counter `wcnt`.
  - IDLE, both `deb` differ from outputs on the same edge: update both outputs on that edge; stay in IDLE.
  - IDLE, only `deb_a` differs from `A`: go to HOLD_A, load `wcnt = PAIR_WINDOW`; outputs unchanged. HOLD_B is symmetric.
  - HOLD_x, other channel's `deb` now differs from its output: update A and B together on that edge; go to IDLE.
  - HOLD_x, held channel's `deb` returns to its output value (debounced glitch): go to IDLE; no output change; no pulse.
  - HOLD_x, none of the above: decrement `wcnt`. The edge on which `wcnt` reaches 0 updates the held output alone and returns to IDLE.
  - If the other-channel event and expiry fall on the same edge, the other-channel event wins: both outputs update.
- Rise pulses:
  - `a_rise`/`b_rise` are registered, asserted for exactly the one cycle following the edge where the output goes 0→1.
  - Falling output edges produce no pulse.
- Reset at any time, including mid-debounce or mid-hold:
  - all flops, outputs, counters and pulses return to 0; FSM returns to IDLE.
  - Raw inputs that are high at reset release are treated as a new press.

## Timing
- Edge k is the first edge that samples a new raw level into `s1`.
- `s2` updates at k+1; `deb` flips at edge k+1+DEBOUNCE_CYCLES.
- Alignment compiled out: A/B change at k+1+DEBOUNCE_CYCLES (k+5 at default).
- Alignment compiled in, lone press: output changes at k+1+DEBOUNCE_CYCLES+PAIR_WINDOW (k+8 at default).
- Alignment compiled in, paired press: both outputs change on the edge the second `deb` flips.
- Pulse is high during the cycle after the output edge.
- No combinational path from any input to any output.

## Configuration
- `AB_PAIR_ALIGN_EN` defined: IDLE/HOLD_A/HOLD_B alignment FSM and `wcnt` are present, as described under Operation.
- `AB_PAIR_ALIGN_EN` undefined: FSM and `wcnt` are absent; outputs follow `deb` with one register; `PAIR_WINDOW` is unused.

## Structure
- Package `ab_cond_pkg` holds:
  - the `ab_state_t` enum (IDLE, HOLD_A, HOLD_B);
  - default constants `AB_DEBOUNCE_DEF = 4` and `AB_PAIR_WINDOW_DEF = 3`.
- Sub-module `ab_debounce_ch` contains one channel's synchroniser, counter and `deb` register; it is instantiated twice.
- Top level holds the alignment FSM and the pulse logic.

## Test plan
Default parameters unless stated.
- Reset: `rst` high 2 cycles with `btn_a = btn_b = 1` → A = B = 0 and pulses 0 throughout reset. After release, alignment off: A and B rise 5 edges after first sample, with a single-cycle `a_rise` and `b_rise`.
- Bounce, alignment off: `btn_a` high 3 cycles, low 1 cycle, then high steady → no A change during the bounce; A rises 5 edges after the final rising sample; exactly one `a_rise`.
- Lone press, alignment on: `btn_a` high from edge k, `btn_b` low → A rises at k+8; B stays 0; one `a_rise` in cycle k+8..k+9.
- Paired press, alignment on: `btn_a` from k, `btn_b` from k+2 → A and B both rise at k+7; `a_rise` and `b_rise` asserted in the same cycle.
- Glitch cancel, alignment on, `PAIR_WINDOW = 8`: `btn_a` high for edges k..k+4, low afterwards → `deb_a` rises at k+5 and falls at k+10 → FSM returns to IDLE; A never rises; no `a_rise`.
- Reset mid-hold, alignment on: `btn_a` press, `rst` asserted at k+6 (inside HOLD_A) → A stays 0; FSM in IDLE. After release with `btn_a` still high, A rises 8 edges after the first post-reset sample.

Source files
------------

// File: rtl/ab_cond_pkg.sv
// Shared types and default constants for the A/B input conditioner.
package ab_cond_pkg;

    // Pair-alignment FSM states: idle, or holding a lone change on A or on B.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } ab_state_t;

    localparam int AB_DEBOUNCE_DEF    = 4;
    localparam int AB_PAIR_WINDOW_DEF = 3;

endpackage

// File: rtl/ab_debounce_ch.sv
// One input channel: two-flop synchroniser followed by a counting debouncer.
// deb_next is the value the debounced register takes on the coming edge, so the
// consumer can register it and track deb with no extra cycle of latency.
module ab_debounce_ch
    import ab_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = AB_DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic deb_next
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          deb;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Bring the asynchronous raw input into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Count consecutive disagreeing samples; flip on the last one, clear on any agreement.
    always_comb begin
        deb_next = deb;
        cnt_next = '0;
        if (s2 != deb) begin
            if (cnt == CNT_LAST) begin
                deb_next = ~deb;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // Debounced state and run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            deb <= deb_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/ab_input_cond.sv
// Two-channel input conditioner feeding the A/B sequence FSM.
// Each raw button is synchronised and debounced; A/B are registered levels and
// a_rise/b_rise are one-cycle pulses following a 0->1 output edge.
// Optional feature macro AB_PAIR_ALIGN_EN: when defined, a lone debounced change
// is held for up to PAIR_WINDOW cycles so that a near-simultaneous change on the
// other channel reaches A and B on the same edge.
module ab_input_cond
    import ab_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = AB_DEBOUNCE_DEF,
    parameter int PAIR_WINDOW     = AB_PAIR_WINDOW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_a,
    input  logic btn_b,
    output logic A,
    output logic B,
    output logic a_rise,
    output logic b_rise
);

    logic deb_next_a;
    logic deb_next_b;
    logic a_next;
    logic b_next;

    ab_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn_a),
        .deb_next (deb_next_a)
    );

    ab_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn_b),
        .deb_next (deb_next_b)
    );

`ifdef AB_PAIR_ALIGN_EN
    localparam int            WW    = $clog2(PAIR_WINDOW + 1);
    localparam logic [WW-1:0] WLOAD = WW'(PAIR_WINDOW);

    ab_state_t     state;
    ab_state_t     state_next;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_next;
    logic          diff_a;
    logic          diff_b;

    assign diff_a = (deb_next_a != A);
    assign diff_b = (deb_next_b != B);

    // Alignment FSM state and hold-window counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // Decide when each debounced change is released to the outputs.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        a_next     = A;
        b_next     = B;
        case (state)
            IDLE: begin
                if (diff_a && diff_b) begin
                    a_next = deb_next_a;
                    b_next = deb_next_b;
                end else if (diff_a) begin
                    state_next = HOLD_A;
                    wcnt_next  = WLOAD;
                end else if (diff_b) begin
                    state_next = HOLD_B;
                    wcnt_next  = WLOAD;
                end
            end
            HOLD_A: begin
                if (diff_b) begin
                    // Partner arrived inside the window (wins over expiry).
                    a_next     = deb_next_a;
                    b_next     = deb_next_b;
                    state_next = IDLE;
                    wcnt_next  = '0;
                end else if (!diff_a) begin
                    // Held change was a glitch that debounced back out.
                    state_next = IDLE;
                    wcnt_next  = '0;
                end else if (wcnt == WW'(1)) begin
                    a_next     = deb_next_a;
                    state_next = IDLE;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next = wcnt - 1'b1;
                end
            end
            HOLD_B: begin
                if (diff_a) begin
                    a_next     = deb_next_a;
                    b_next     = deb_next_b;
                    state_next = IDLE;
                    wcnt_next  = '0;
                end else if (!diff_b) begin
                    state_next = IDLE;
                    wcnt_next  = '0;
                end else if (wcnt == WW'(1)) begin
                    b_next     = deb_next_b;
                    state_next = IDLE;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next = wcnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                wcnt_next  = '0;
            end
        endcase
    end
`else
    // Without alignment the outputs simply track the debounced state.
    assign a_next = deb_next_a;
    assign b_next = deb_next_b;
`endif

    // Registered levels and rise pulses (pulse high the cycle after a 0->1 edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            A      <= 1'b0;
            B      <= 1'b0;
            a_rise <= 1'b0;
            b_rise <= 1'b0;
        end else begin
            A      <= a_next;
            B      <= b_next;
            a_rise <= a_next & ~A;
            b_rise <= b_next & ~B;
        end
    end

endmodule
